dcache_linebank: RTL
====================

Name: dcache_linebank

Overview:
- Parametrised successor of the byte-banked dcache data store.
- Holds 2**CACHEADDRBITS words of DATABITS, split into BANKNUM byte-lane single-port banks with registered read.
- Owns a line sequencer: FILL writes a whole line from the big-memory side, and DRAIN streams a whole line out for write-back under valid/ready.
- CPU-side byte-enabled access is allowed only while idle. The cache controller sequences misses via start/busy/done.

Parameters:
DATABITS, 32, word width; must equal BANKNUM*CACHEDATABITS
CACHEDATABITS, 8, bank (byte-lane) width
CACHEADDRBITS, 5, word address width; depth = 2**CACHEADDRBITS
LINEWORDBITS, 2, log2 words per line; must be < CACHEADDRBITS
BANKNUM, DATABITS/CACHEDATABITS, derived bank count
LINEBITS, CACHEADDRBITS-LINEWORDBITS, derived line index width

Ports:
clk  in  1  clock, rising edge
reset_n  in  1  asynchronous active-low reset
dcache_in  in  DATABITS  CPU write data
dcache_addr  in  CACHEADDRBITS  CPU word address
byteenable  in  BANKNUM  per-lane write enable
dcache_wrreq  in  1  CPU write strobe
dcache_rdreq  in  1  CPU read strobe
data_out  out  DATABITS  CPU read data
data_out_valid  out  1  data_out holds the result of the previous-cycle read
fill_start  in  1  begin line fill at line_index
drain_start  in  1  begin line drain at line_index
line_index  in  LINEBITS  line selected, sampled on the accepted start
line_in  in  DATABITS  fill word
line_in_valid  in  1  fill word present
line_out  out  DATABITS  drain word (registered)
line_out_valid  out  1  drain word present
line_out_ready  in  1  downstream accepts line_out
busy  out  1  high whenever state != IDLE
done  out  1  one-cycle pulse when a fill or drain completes

Behaviour:
- Reset (async assert, sync release): state=IDLE, word counter=0, line register=0. All outputs 0. RAM contents are not cleared.
- Reset mid-FILL/DRAIN: the operation is abandoned, no done pulse, and a partial line stays in RAM.
- Address presented to the banks = {line register, counter} in FILL/DRAIN, dcache_addr in IDLE.
- IDLE, CPU port:
  - wrreq writes lanes with byteenable[i]=1 at the next edge.
  - rdreq (without wrreq) makes data_out valid on the following cycle, with data_out_valid=1 for exactly that cycle.
  - wrreq and rdreq together: write only, data_out_valid=0.
- IDLE, starts:
  - drain_start has priority over fill_start when both are high.
  - An accepted start latches line_index, clears the counter, and ignores CPU strobes in that cycle.
  - drain_start -> DRAIN_RD. fill_start (alone) -> FILL.
- FILL:
  - Each cycle with line_in_valid=1 writes line_in to all banks at {line,counter}, and the counter increments.
  - On the write with counter=2**LINEWORDBITS-1, go to IDLE with done=1 in the next cycle.
  - line_in_valid=0 stalls the fill without limit.
- DRAIN_RD: bank read issued at {line,counter}. Go to DRAIN_OUT.
- DRAIN_OUT:
  - On entry, line_out loads the bank output and line_out_valid=1.
  - line_out and line_out_valid hold stable until line_out_ready=1.
  - On the handshake, line_out_valid drops next cycle. If counter was last, go to IDLE with done=1; otherwise increment counter and go to DRAIN_RD.
  - Throughput is 1 word per 2 cycles minimum.
- Non-IDLE state: fill_start, drain_start, dcache_wrreq and dcache_rdreq are ignored, and data_out_valid=0. The controller must wait for busy=0.
- Counter wraps only within the line; line register is never modified during an operation.
- done is asserted together with busy=0 in the same cycle, so a new start is accepted in that same cycle.

Test Plan:
- Reset: assert reset_n=0 mid-DRAIN with line_out_valid=1 -> all outputs 0 immediately; after release, busy=0 and no done pulse.
- CPU byte write: write 0xAABBCCDD to addr 5 with be=1111, then 0x11223344 with be=0101, then read addr 5 -> data_out=0xAA22CC44, data_out_valid=1 exactly one cycle after rdreq.
- Fill: fill_start with line_index=3, then 4 words 0x10..0x13 with line_in_valid gaps -> done pulses once after the 4th word; CPU reads of addr 12..15 return 0x10..0x13.
- Drain with backpressure: drain line 3 with line_out_ready low for 3 cycles on word 1 -> line_out is stable at 0x11 throughout; sequence 0x10..0x13 each handshaken once; done pulses after the last.
- Simultaneous starts: fill_start=drain_start=1 -> DRAIN is taken; busy=1; CPU wrreq during busy leaves RAM unchanged (verified by a later read).
- Parametrisation: DATABITS=64, CACHEDATABITS=16, LINEWORDBITS=3 -> BANKNUM=4; fill and drain move 8 words; a be=0010 write updates only bits 31:16.

Source files
------------

// File: rtl/dcache_linebank_if.sv
// Bus bundle for dcache_linebank: CPU word port, line fill/drain port and sequencer status.
// The master side belongs to the cache controller, the slave side to the data store.
interface dcache_linebank_if #(
  parameter int unsigned DATABITS      = 32,
  parameter int unsigned CACHEDATABITS = 8,
  parameter int unsigned CACHEADDRBITS = 5,
  parameter int unsigned LINEWORDBITS  = 2
);
  localparam int unsigned BANKNUM  = DATABITS / CACHEDATABITS;
  localparam int unsigned LINEBITS = CACHEADDRBITS - LINEWORDBITS;

  logic [DATABITS-1:0]      dcache_in;
  logic [CACHEADDRBITS-1:0] dcache_addr;
  logic [BANKNUM-1:0]       byteenable;
  logic                     dcache_wrreq;
  logic                     dcache_rdreq;
  logic [DATABITS-1:0]      data_out;
  logic                     data_out_valid;
  logic                     fill_start;
  logic                     drain_start;
  logic [LINEBITS-1:0]      line_index;
  logic [DATABITS-1:0]      line_in;
  logic                     line_in_valid;
  logic [DATABITS-1:0]      line_out;
  logic                     line_out_valid;
  logic                     line_out_ready;
  logic                     busy;
  logic                     done;

  modport master (
    output dcache_in, dcache_addr, byteenable, dcache_wrreq, dcache_rdreq,
           fill_start, drain_start, line_index, line_in, line_in_valid, line_out_ready,
    input  data_out, data_out_valid, line_out, line_out_valid, busy, done
  );

  modport slave (
    input  dcache_in, dcache_addr, byteenable, dcache_wrreq, dcache_rdreq,
           fill_start, drain_start, line_index, line_in, line_in_valid, line_out_ready,
    output data_out, data_out_valid, line_out, line_out_valid, busy, done
  );
endinterface

// File: rtl/dcache_linebank.sv
// Byte-lane banked dcache data store with a line sequencer for whole-line fill and drain.
// CPU byte-enabled access is served only while the sequencer is idle.
module dcache_linebank #(
  parameter int unsigned DATABITS      = 32,
  parameter int unsigned CACHEDATABITS = 8,
  parameter int unsigned CACHEADDRBITS = 5,
  parameter int unsigned LINEWORDBITS  = 2
) (
  input logic              clk,
  input logic              reset_n,
  dcache_linebank_if.slave bus
);
  localparam int unsigned BANKNUM  = DATABITS / CACHEDATABITS;
  localparam int unsigned LINEBITS = CACHEADDRBITS - LINEWORDBITS;
  localparam int unsigned DEPTH    = 2 ** CACHEADDRBITS;

  typedef enum logic [1:0] {StIdle, StFill, StDrainRd, StDrainOut} state_e;

  state_e                   state_q;
  logic [LINEWORDBITS-1:0]  cnt_q;
  logic [LINEBITS-1:0]      line_q;
  logic                     done_q;
  logic                     line_out_valid_q;
  logic                     data_out_valid_q;
  logic [DATABITS-1:0]      rd_data;

  logic                     idle;
  logic                     start;
  logic                     cpu_wr;
  logic                     cpu_rd;
  logic                     fill_wr;
  logic                     bank_rd;
  logic                     cnt_last;
  logic [CACHEADDRBITS-1:0] bank_addr;
  logic [DATABITS-1:0]      wr_data;
  logic [BANKNUM-1:0]       lane_we;

  // An accepted start swallows any CPU strobe in the same cycle.
  always_comb begin
    idle      = (state_q == StIdle);
    start     = idle & (bus.fill_start | bus.drain_start);
    cpu_wr    = idle & ~start & bus.dcache_wrreq;
    cpu_rd    = idle & ~start & bus.dcache_rdreq & ~bus.dcache_wrreq;
    fill_wr   = (state_q == StFill) & bus.line_in_valid;
    bank_rd   = cpu_rd | (state_q == StDrainRd);
    cnt_last  = &cnt_q;
    bank_addr = idle ? bus.dcache_addr : {line_q, cnt_q};
    wr_data   = idle ? bus.dcache_in : bus.line_in;
    lane_we   = fill_wr ? '1 : (cpu_wr ? bus.byteenable : '0);
  end

  for (genvar b = 0; b < BANKNUM; b++) begin : g_bank
    logic [CACHEDATABITS-1:0] mem [DEPTH];
    logic [CACHEDATABITS-1:0] rd_lane_q;

    always_ff @(posedge clk) begin
      if (lane_we[b]) begin
        mem[bank_addr] <= wr_data[b*CACHEDATABITS +: CACHEDATABITS];
      end
    end

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        rd_lane_q <= '0;
      end else if (bank_rd) begin
        rd_lane_q <= mem[bank_addr];
      end
    end

    assign rd_data[b*CACHEDATABITS +: CACHEDATABITS] = rd_lane_q;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q          <= StIdle;
      cnt_q            <= '0;
      line_q           <= '0;
      done_q           <= 1'b0;
      line_out_valid_q <= 1'b0;
      data_out_valid_q <= 1'b0;
    end else begin
      done_q           <= 1'b0;
      data_out_valid_q <= cpu_rd;
      unique case (state_q)
        StIdle: begin
          if (bus.drain_start) begin
            state_q <= StDrainRd;
            line_q  <= bus.line_index;
            cnt_q   <= '0;
          end else if (bus.fill_start) begin
            state_q <= StFill;
            line_q  <= bus.line_index;
            cnt_q   <= '0;
          end
        end
        StFill: begin
          if (bus.line_in_valid) begin
            cnt_q <= cnt_q + 1'b1;
            if (cnt_last) begin
              state_q <= StIdle;
              done_q  <= 1'b1;
            end
          end
        end
        StDrainRd: begin
          // Bank output register feeds line_out directly, so it is valid on entry.
          state_q          <= StDrainOut;
          line_out_valid_q <= 1'b1;
        end
        StDrainOut: begin
          if (bus.line_out_ready) begin
            line_out_valid_q <= 1'b0;
            if (cnt_last) begin
              state_q <= StIdle;
              done_q  <= 1'b1;
            end else begin
              cnt_q   <= cnt_q + 1'b1;
              state_q <= StDrainRd;
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.data_out       = rd_data;
  assign bus.data_out_valid = data_out_valid_q;
  assign bus.line_out       = rd_data;
  assign bus.line_out_valid = line_out_valid_q;
  assign bus.busy           = (state_q != StIdle);
  assign bus.done           = done_q;
endmodule
